// File: rtl/gesture_frame_filter.sv
// gesture_frame_filter: parses, validates and debounces 3-byte gesture frames with link timeout
module gesture_frame_filter #(
    parameter int unsigned STABLE_COUNT   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] gesture,
    output logic       gesture_update,
    output logic       frame_err,
    output logic       link_timeout,
    output logic [7:0] err_count
);
    localparam int          TW   = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TSAT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TPRE = TW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  SC   = 4'(STABLE_COUNT);

    typedef enum logic [1:0] {HUNT, GOT_HDR, GOT_CODE} state_t;

    state_t        state, cur, state_nxt;
    logic [7:0]    code_q, ok_code, cand;
    logic [3:0]    cnt, cnt_upd;
    logic [TW-1:0] tmo_cnt;
    logic          frame_ok, ok_nxt, err_nxt, legal, tmo_fire, commit;

    // Timeout expiry squashes the parser back to HUNT before the current byte is parsed
    always_comb begin
        tmo_fire  = (TIMEOUT_CYCLES != 0) && !frame_ok && (tmo_cnt == TPRE);
        cur       = tmo_fire ? HUNT : state;
        legal     = (rx_data == ~code_q) &&
                    (code_q == 8'h00 || code_q == 8'h01 || code_q == 8'h02 || code_q == 8'h04);
        state_nxt = cur;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (rx_valid) begin
            case (cur)
                HUNT:     state_nxt = rx_data == HEADER ? GOT_HDR : HUNT;
                GOT_HDR:  state_nxt = GOT_CODE;
                default: begin
                    state_nxt = HUNT;
                    ok_nxt    = legal;
                    err_nxt   = !legal;
                end
            endcase
        end
    end

    // Debounce: the candidate always becomes the incoming code, only the run length differs
    always_comb begin
        cnt_upd = ok_code == cand ? (cnt >= SC ? SC : cnt + 4'd1) : 4'd1;
        commit  = frame_ok && cnt_upd == SC && ok_code != gesture;
    end

    // Parser state, code latch and registered frame verdicts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            code_q    <= 8'h00;
            frame_ok  <= 1'b0;
            ok_code   <= 8'h00;
            frame_err <= 1'b0;
            err_count <= 8'h00;
        end else begin
            state     <= state_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            if (rx_valid && cur == GOT_HDR) code_q <= rx_data;
            if (ok_nxt) ok_code <= code_q;
            if (err_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    // Silence counter: cleared by each good frame, holds at saturation so expiry fires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt <= '0;
        else if (frame_ok) tmo_cnt <= '0;
        else if (TIMEOUT_CYCLES != 0 && tmo_cnt != TSAT) tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Candidate tracking, commit of the gesture and the neutral fallback on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand           <= 8'h00;
            cnt            <= 4'd0;
            gesture        <= 8'h00;
            gesture_update <= 1'b0;
            link_timeout   <= 1'b0;
        end else begin
            gesture_update <= 1'b0;
            link_timeout   <= 1'b0;
            if (tmo_fire) begin
                cand           <= 8'h00;
                cnt            <= 4'd0;
                link_timeout   <= 1'b1;
                gesture        <= 8'h00;
                gesture_update <= gesture != 8'h00;
            end else if (frame_ok) begin
                cand <= ok_code;
                cnt  <= cnt_upd;
                if (commit) begin
                    gesture        <= ok_code;
                    gesture_update <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gesture_frame_filter.sv
// tb_gesture_frame_filter: directed scenario checks for the gesture frame filter
module tb_gesture_frame_filter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] gesture, err_count;
    logic       gesture_update, frame_err, link_timeout;
    int         checks = 0;
    int         errors = 0;
    int         n_upd = 0;
    int         n_tmo = 0;
    int         n_err = 0;

    gesture_frame_filter #(.STABLE_COUNT(3), .TIMEOUT_CYCLES(100), .HEADER(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .gesture(gesture), .gesture_update(gesture_update), .frame_err(frame_err),
        .link_timeout(link_timeout), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            n_upd = n_upd + int'(gesture_update);
            n_tmo = n_tmo + int'(link_timeout);
            n_err = n_err + int'(frame_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] k);
        send(8'hA5);
        send(c);
        send(k);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gesture !== 8'h00) begin errors++; $display("FAIL reset_gesture got %0h exp 00", gesture); end
        checks++; if ({gesture_update, frame_err, link_timeout} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {gesture_update, frame_err, link_timeout}); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    endtask

    task automatic test_back_to_back();
        int u0;
        do_reset();
        u0 = n_upd;
        frame(8'h01, 8'hFE);
        frame(8'h01, 8'hFE);
        checks++; if (gesture !== 8'h00) begin errors++; $display("FAIL b2b_early got %0h exp 00", gesture); end
        frame(8'h01, 8'hFE);
        checks++; if (gesture !== 8'h00 || gesture_update !== 1'b0) begin errors++; $display("FAIL b2b_k1 got %0h/%b exp 00/0", gesture, gesture_update); end
        tick();
        checks++; if (gesture !== 8'h01 || gesture_update !== 1'b1) begin errors++; $display("FAIL b2b_k2 got %0h/%b exp 01/1", gesture, gesture_update); end
        tick();
        checks++; if (n_upd - u0 !== 1) begin errors++; $display("FAIL b2b_pulses got %0d exp 1", n_upd - u0); end
    endtask

    task automatic test_debounce();
        do_reset();
        frame(8'h02, 8'hFD);
        frame(8'h04, 8'hFB);
        frame(8'h02, 8'hFD);
        frame(8'h02, 8'hFD);
        tick();
        checks++; if (gesture !== 8'h00) begin errors++; $display("FAIL debounce_hold got %0h exp 00", gesture); end
        frame(8'h02, 8'hFD);
        tick();
        checks++; if (gesture !== 8'h02 || gesture_update !== 1'b1) begin errors++; $display("FAIL debounce_commit got %0h/%b exp 02/1", gesture, gesture_update); end
    endtask

    task automatic test_errors();
        int e0;
        do_reset();
        frame(8'h02, 8'hFD);
        frame(8'h02, 8'hFD);
        frame(8'h02, 8'hFD);
        tick();
        e0 = n_err;
        send(8'h33);
        send(8'h5A);
        tick();
        checks++; if (n_err !== e0 || err_count !== 8'd0) begin errors++; $display("FAIL garbage got %0d/%0d exp 0/0", n_err - e0, err_count); end
        frame(8'h01, 8'h00);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_check got %b exp 1", frame_err); end
        frame(8'h08, 8'hF7);
        checks++; if (frame_err !== 1'b1 || err_count !== 8'd2) begin errors++; $display("FAIL bad_code got %b/%0d exp 1/2", frame_err, err_count); end
        tick();
        tick();
        checks++; if (gesture !== 8'h02) begin errors++; $display("FAIL err_gesture got %0h exp 02", gesture); end
    endtask

    task automatic test_timeout();
        int n, t0, u0;
        do_reset();
        frame(8'h04, 8'hFB);
        frame(8'h04, 8'hFB);
        frame(8'h04, 8'hFB);
        tick();
        n = 1;
        checks++; if (gesture !== 8'h04) begin errors++; $display("FAIL tmo_commit got %0h exp 04", gesture); end
        while (!link_timeout && n < 300) begin tick(); n++; end
        checks++; if (n !== 101) begin errors++; $display("FAIL tmo_latency got %0d exp 101", n); end
        checks++; if (gesture_update !== 1'b1 || gesture !== 8'h00) begin errors++; $display("FAIL tmo_neutral got %b/%0h exp 1/00", gesture_update, gesture); end
        tick();
        t0 = n_tmo;
        u0 = n_upd;
        repeat (200) tick();
        checks++; if (n_tmo !== t0 || n_upd !== u0) begin errors++; $display("FAIL tmo_repeat got %0d/%0d exp 0/0", n_tmo - t0, n_upd - u0); end
    endtask

    task automatic test_coincident();
        int t0;
        do_reset();
        frame(8'h01, 8'hFE);
        t0 = n_tmo;
        repeat (97) tick();
        frame(8'h01, 8'hFE);
        tick();
        tick();
        checks++; if (n_tmo !== t0) begin errors++; $display("FAIL coincident_tmo got %0d exp 0", n_tmo - t0); end
        frame(8'h01, 8'hFE);
        tick();
        checks++; if (gesture !== 8'h01 || gesture_update !== 1'b1) begin errors++; $display("FAIL coincident_count got %0h/%b exp 01/1", gesture, gesture_update); end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        do_reset();
        send(8'hA5);
        send(8'h01);
        rst_n = 1'b0;
        #2;
        checks++; if (gesture !== 8'h00 || err_count !== 8'd0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_state got %0h/%0d/%b exp 00/0/0", gesture, err_count, frame_err); end
        tick();
        rst_n = 1'b1;
        tick();
        e0 = n_err;
        send(8'h01);
        send(8'hFE);
        tick();
        checks++; if (n_err !== e0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %0d exp 0", n_err - e0); end
        frame(8'h01, 8'hFE);
        frame(8'h01, 8'hFE);
        tick();
        checks++; if (gesture !== 8'h00) begin errors++; $display("FAIL midrst_drop got %0h exp 00", gesture); end
    endtask

    task automatic test_saturation();
        int n, e0, miss;
        do_reset();
        n = 0;
        while (!link_timeout && n < 300) begin tick(); n++; end
        checks++; if (link_timeout !== 1'b1 || gesture_update !== 1'b0) begin errors++; $display("FAIL idle_tmo got %b/%b exp 1/0", link_timeout, gesture_update); end
        e0 = n_err;
        miss = 0;
        for (int i = 0; i < 300; i++) begin
            frame(8'h01, 8'h00);
            if (frame_err !== 1'b1) miss++;
            if (i == 0) begin
                checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL sat_first got %0d exp 1", err_count); end
            end
        end
        tick();
        checks++; if (miss !== 0 || n_err - e0 !== 300) begin errors++; $display("FAIL sat_pulses got %0d missing %0d exp 300", n_err - e0, miss); end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", err_count); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_debounce();
        test_errors();
        test_timeout();
        test_coincident();
        test_reset_mid_frame();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
